msg_block_assembler: RTL and testbench
======================================

MSG_BLOCK_ASSEMBLER -- requirements
Module: msg_block_assembler

Interface
REQ-001 Parameter BLOCK_BYTES, default 64, meaning bytes per compression block (fixed; 6-bit index).
REQ-002 Parameter WORD_W, default 32, meaning message word width m[i]; 16 words per block.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nreset  in  1  reset, synchronous, active-low.
REQ-005 data_v_i  in  1  registered byte valid from the I/O front end.
REQ-006 data_i  in  8  message byte.
REQ-007 data_idx_i  in  6  byte position within current block.
REQ-008 block_first_i  in  1  current block is first of message.
REQ-009 block_last_i  in  1  current block is last of message.
REQ-010 ll_i  in  64  total message length in bytes, stable before first byte.
REQ-011 block_ready_i  in  1  compression core accepts block this cycle.
REQ-012 block_v_o  out  1  complete block presented.
REQ-013 m_o  out  512  message block, m[i] = m_o[32*i+:32], little-endian bytes.
REQ-014 t_o  out  64  byte offset counter for this block.
REQ-015 first_o / last_o  out  1 each  block flags, stable while block_v_o.
REQ-016 ready_v_o  out  1  high when able to take a byte (state FILL).
REQ-017 overflow_o  out  1  sticky: byte arrived while not ready.

Function
REQ-018 FSM states FILL, FULL; reset state FILL.
REQ-019 FILL: each data_v_i writes data_i into byte lane data_idx_i of buffer; rcv_cnt (64-bit) increments by 1.
REQ-020 FILL->FULL the cycle after a byte with data_idx_i==63, or a byte with block_last_i=1 making rcv_cnt+1==ll_i.
REQ-021 Block capture latches first_o=block_first_i, last_o=block_last_i of the completing byte.
REQ-022 t_o on non-last block = rcv_cnt after the completing byte (multiple of 64); on last block t_o = ll_i.
REQ-023 Unwritten lanes of a partial last block SHALL read zero (buffer cleared on every hand-off).
REQ-024 FULL: block_v_o=1, ready_v_o=0; m_o, t_o, first_o, last_o held until block_v_o & block_ready_i.
REQ-025 Hand-off cycle: buffer cleared, FULL->FILL next cycle; if last_o was set, rcv_cnt cleared to 0.
REQ-026 Latency: completing byte at cycle N -> block_v_o high at N+1; block_ready_i already high -> hand-off at N+1, ready_v_o high at N+2.
REQ-027 data_v_i in FULL: byte dropped, buffer unchanged, overflow_o set until reset.
REQ-028 data_idx_i not equal to rcv_cnt mod 64 in FILL: byte still written at data_idx_i, no error (upstream owns ordering).
REQ-029 rcv_cnt wraps modulo 2^64; ll_i==0 is out of scope for this block.

Reset
REQ-030 nreset low at clk edge: state FILL, block_v_o=0, ready_v_o=1, overflow_o=0, rcv_cnt=0, t_o=0, first_o=0, last_o=0, buffer/m_o=0.
REQ-031 Reset mid-block or in FULL discards all captured data; no block_v_o pulse follows.

Structure
REQ-032 Shared package: BLOCK_BYTES, WORD_W, word count 16, FSM state encoding, t width 64.
REQ-033 One sub-module, byte_lane_buffer: 64x8 register array with indexed write, synchronous clear, flat 512-bit read.

Verification
REQ-034 ll=64, bytes 0x00..0x3F, first=last=1, block_ready_i=1 -> one block, m[0]=0x03020100, m[15]=0x3F3E3D3C, t=64, first=last=1.
REQ-035 ll=3, bytes 0x61,0x62,0x63, first=last=1 -> m[0]=0x00636261, m[1..15]=0, t=3, block_v_o at cycle after third byte.
REQ-036 ll=130 -> three blocks: t=64 first=1 last=0; t=128 first=0 last=0; t=130 last=1, m[0]=byte128|byte129<<8, rest zero.
REQ-037 block_ready_i held low 10 cycles after full block -> block_v_o and m_o stable 10 cycles, ready_v_o=0; byte injected -> overflow_o=1, m_o unchanged.
REQ-038 nreset asserted after 20 bytes of ll=64 message, then new ll=3 message -> only ll=3 block emitted, t=3, upper lanes zero.

Source files
------------

// File: rtl/msg_block_assembler_pkg.sv
// Shared constants and FSM encoding for the message block assembler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package msg_block_assembler_pkg;
  localparam int BLOCK_BYTES = 64;
  localparam int WORD_W      = 32;
  localparam int WORDS       = 16;
  localparam int IDX_W       = 6;
  localparam int T_W         = 64;
  localparam int BLOCK_W     = BLOCK_BYTES * 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/msg_block_assembler_if.sv
// Byte-in / block-out bundle between the I/O front end, assembler and compression core.
// Latency: n/a (wires only).
// Backpressure: block_ready_i from the core stalls the block; ready_v_o tells the front end to hold bytes.
interface msg_block_assembler_if;
  import msg_block_assembler_pkg::*;

  logic               data_v_i;
  logic [7:0]         data_i;
  logic [IDX_W-1:0]   data_idx_i;
  logic               block_first_i;
  logic               block_last_i;
  logic [T_W-1:0]     ll_i;
  logic               block_ready_i;
  logic               block_v_o;
  logic [BLOCK_W-1:0] m_o;
  logic [T_W-1:0]     t_o;
  logic               first_o;
  logic               last_o;
  logic               ready_v_o;
  logic               overflow_o;

  // Upstream side: front end plus compression core.
  modport master (
    output data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i, block_ready_i,
    input  block_v_o, m_o, t_o, first_o, last_o, ready_v_o, overflow_o
  );

  // Assembler side.
  modport slave (
    input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i, ll_i, block_ready_i,
    output block_v_o, m_o, t_o, first_o, last_o, ready_v_o, overflow_o
  );
endinterface

// File: rtl/msg_block_assembler_byte_lane_buffer.sv
// Byte-lane register array: one indexed byte write per cycle, synchronous clear, flat read.
// Latency: write visible on the flat output the cycle after it is presented.
// Backpressure: none; clear has priority over write.
module byte_lane_buffer #(
  parameter int NBYTES = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [7:0]        dat,
  output logic [NBYTES*8-1:0] flat_o
);
  logic [7:0] lane_q [NBYTES];
  logic [7:0] lane_d [NBYTES];

  // Next lane contents: a clear wipes every lane, otherwise one lane may take a byte.
  always_comb begin
    lane_d = lane_q;
    if (clr) begin
      for (int i = 0; i < NBYTES; i++) lane_d[i] = 8'h00;
    end else if (we) begin
      lane_d[idx] = dat;
    end
  end

  // Lane registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < NBYTES; i++) lane_q[i] <= 8'h00;
    end else begin
      lane_q <= lane_d;
    end
  end

  for (genvar g = 0; g < NBYTES; g++) begin : g_flat
    assign flat_o[g*8 +: 8] = lane_q[g];
  end
endmodule

// File: rtl/msg_block_assembler.sv
// Collects message bytes into 64-byte blocks with offset counter and first/last flags.
// Latency: completing byte at cycle N -> block_v_o at N+1; accepted hand-off reopens FILL at N+2.
// Backpressure: block held while block_ready_i low; bytes arriving then are dropped and flagged.
module msg_block_assembler #(
  parameter int BLOCK_BYTES = msg_block_assembler_pkg::BLOCK_BYTES,
  parameter int WORD_W      = msg_block_assembler_pkg::WORD_W
) (
  input  logic clk,
  input  logic nreset,
  msg_block_assembler_if.slave bus
);
  import msg_block_assembler_pkg::*;

  localparam int NWORDS = (BLOCK_BYTES * 8) / WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  state_t           state_q, state_d;
  logic [T_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             overflow_q, overflow_d;
  logic [T_W-1:0]   cnt_inc;
  logic             buf_we;
  logic             buf_clr;
  logic [BLOCK_W-1:0] flat;
  logic [BLOCK_W-1:0] m_w;

  // Next-state and block capture: FILL takes bytes, FULL waits for the core to accept.
  always_comb begin
    state_d    = state_q;
    rcv_cnt_d  = rcv_cnt_q;
    t_d        = t_q;
    first_d    = first_q;
    last_d     = last_q;
    overflow_d = overflow_q | (bus.data_v_i & (state_q == FULL));
    buf_we     = 1'b0;
    buf_clr    = 1'b0;
    cnt_inc    = rcv_cnt_q + T_W'(1);
    case (state_q)
      FILL: begin
        if (bus.data_v_i) begin
          buf_we    = 1'b1;
          rcv_cnt_d = cnt_inc;
          // A block closes on its top lane, or on the final byte of the message.
          if ((bus.data_idx_i == LAST_IDX) || (bus.block_last_i && (cnt_inc == bus.ll_i))) begin
            state_d = FULL;
            first_d = bus.block_first_i;
            last_d  = bus.block_last_i;
            t_d     = bus.block_last_i ? bus.ll_i : cnt_inc;
          end
        end
      end
      FULL: begin
        if (bus.block_ready_i) begin
          buf_clr = 1'b1;
          state_d = FILL;
          if (last_q) rcv_cnt_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and block metadata registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= FILL;
      rcv_cnt_q  <= '0;
      t_q        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcv_cnt_q  <= rcv_cnt_d;
      t_q        <= t_d;
      first_q    <= first_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  byte_lane_buffer #(
    .NBYTES (BLOCK_BYTES),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk    (clk),
    .nreset (nreset),
    .clr    (buf_clr),
    .we     (buf_we),
    .idx    (bus.data_idx_i),
    .dat    (bus.data_i),
    .flat_o (flat)
  );

  // Word view of the buffer: m[i] occupies bits [WORD_W*i +: WORD_W], bytes little-endian.
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    assign m_w[w*WORD_W +: WORD_W] = flat[w*WORD_W +: WORD_W];
  end

  assign bus.m_o        = m_w;
  assign bus.block_v_o  = (state_q == FULL);
  assign bus.ready_v_o  = (state_q == FILL);
  assign bus.t_o        = t_q;
  assign bus.first_o    = first_q;
  assign bus.last_o     = last_q;
  assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_msg_block_assembler.sv
// Self-checking bench: directed and random messages against a chunking reference model.
// Latency: checks block_v_o the cycle after each byte and ready_v_o after each hand-off.
// Backpressure: exercises held blocks, overflow injection and mid-message reset.
module tb_msg_block_assembler;
  import msg_block_assembler_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  msg_block_assembler_if bus();

  msg_block_assembler dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0]   msg [256];
  logic         exp_ovf;
  logic [511:0] last_m;
  logic [63:0]  last_t;
  logic         last_first;
  logic         last_last;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference block k: message bytes 64k..64k+63 that exist, zero beyond the message end.
  function automatic logic [511:0] exp_block(input int ll, input int k);
    logic [511:0] m;
    m = '0;
    for (int b = 0; b < 64; b++)
      if (64 * k + b < ll) m[8*b +: 8] = msg[64*k + b];
    return m;
  endfunction

  // mode 0: core always ready; 1: random hold; 2: hold 10 cycles with a byte injected mid-hold.
  task automatic send_msg(input int ll, input int mode);
    int nb;
    nb = (ll + 63) / 64;
    bus.ll_i = 64'(ll);
    for (int i = 0; i < ll; i++) begin
      int k;
      int hold;
      bit completes;
      logic [511:0] em;
      logic [63:0]  et;
      k = i / 64;
      completes = ((i % 64) == 63) || (i == ll - 1);
      repeat ($urandom_range(0, 2)) tick;
      chk("ready_v_before_byte", bus.ready_v_o, 1);
      bus.data_v_i      = 1'b1;
      bus.data_i        = msg[i];
      bus.data_idx_i    = 6'(i % 64);
      bus.block_first_i = (k == 0);
      bus.block_last_i  = (k == nb - 1);
      bus.block_ready_i = (mode == 0);
      tick;
      bus.data_v_i = 1'b0;
      chk("block_v_after_byte", bus.block_v_o, completes);
      if (completes) begin
        em = exp_block(ll, k);
        et = (k == nb - 1) ? 64'(ll) : 64'(64 * (k + 1));
        chk("block_m", bus.m_o, em);
        chk("block_t", bus.t_o, et);
        chk("block_first", bus.first_o, (k == 0));
        chk("block_last", bus.last_o, (k == nb - 1));
        chk("ready_v_in_full", bus.ready_v_o, 0);
        last_m     = bus.m_o;
        last_t     = bus.t_o;
        last_first = bus.first_o;
        last_last  = bus.last_o;
        if (mode != 0) begin
          hold = (mode == 2) ? 10 : $urandom_range(0, 4);
          for (int h = 0; h < hold; h++) begin
            if (mode == 2 && h == 5) begin
              bus.data_v_i   = 1'b1;
              bus.data_i     = 8'hAA;
              bus.data_idx_i = 6'd0;
              exp_ovf        = 1'b1;
            end
            tick;
            bus.data_v_i = 1'b0;
            chk("hold_block_v", bus.block_v_o, 1);
            chk("hold_ready_v", bus.ready_v_o, 0);
            chk("hold_m_stable", bus.m_o, em);
            chk("hold_t_stable", bus.t_o, et);
            chk("hold_overflow", bus.overflow_o, exp_ovf);
          end
          bus.block_ready_i = 1'b1;
        end
        tick;
        bus.block_ready_i = 1'b0;
        chk("after_handoff_block_v", bus.block_v_o, 0);
        chk("after_handoff_ready_v", bus.ready_v_o, 1);
        chk("after_handoff_cleared", bus.m_o, 0);
      end
    end
  endtask

  task automatic check_reset_state;
    chk("rst_block_v", bus.block_v_o, 0);
    chk("rst_ready_v", bus.ready_v_o, 1);
    chk("rst_overflow", bus.overflow_o, 0);
    chk("rst_t", bus.t_o, 0);
    chk("rst_first", bus.first_o, 0);
    chk("rst_last", bus.last_o, 0);
    chk("rst_m", bus.m_o, 0);
  endtask

  initial begin
    nreset            = 1'b0;
    bus.data_v_i      = 1'b0;
    bus.data_i        = 8'h00;
    bus.data_idx_i    = 6'd0;
    bus.block_first_i = 1'b0;
    bus.block_last_i  = 1'b0;
    bus.ll_i          = 64'd0;
    bus.block_ready_i = 1'b0;
    exp_ovf           = 1'b0;
    tick;
    tick;
    check_reset_state();
    nreset = 1'b1;
    tick;

    // Full single block, counting bytes, core always ready.
    for (int i = 0; i < 64; i++) msg[i] = 8'(i);
    send_msg(64, 0);
    chk("full_m0", last_m[31:0], 32'h03020100);
    chk("full_m15", last_m[511:480], 32'h3F3E3D3C);
    chk("full_t", last_t, 64);
    chk("full_first_last", {last_first, last_last}, 2'b11);

    // Three-byte message: partial block, upper lanes zero.
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    chk("abc_m0", last_m[31:0], 32'h00636261);
    chk("abc_rest_zero", last_m[511:32], 0);
    chk("abc_t", last_t, 3);

    // 130-byte message spanning three blocks with random hold.
    for (int i = 0; i < 130; i++) msg[i] = 8'($urandom);
    send_msg(130, 1);
    chk("m130_last_m0", last_m[31:0], {16'h0000, msg[129], msg[128]});
    chk("m130_last_t", last_t, 130);

    // Held block with a byte injected while FULL.
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    send_msg(64, 2);

    // Random message lengths and contents.
    repeat (6) begin
      int ll;
      ll = $urandom_range(1, 200);
      for (int i = 0; i < ll; i++) msg[i] = 8'($urandom);
      send_msg(ll, 1);
    end

    // Reset part-way through a 64-byte message, then a fresh 3-byte message.
    bus.ll_i = 64'd64;
    for (int i = 0; i < 20; i++) begin
      bus.data_v_i      = 1'b1;
      bus.data_i        = 8'($urandom);
      bus.data_idx_i    = 6'(i);
      bus.block_first_i = 1'b1;
      bus.block_last_i  = 1'b1;
      tick;
    end
    bus.data_v_i = 1'b0;
    nreset = 1'b0;
    exp_ovf = 1'b0;
    tick;
    check_reset_state();
    nreset = 1'b1;
    tick;
    chk("post_reset_no_block", bus.block_v_o, 0);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 1);
    chk("post_reset_m0", last_m[31:0], 32'h00636261);
    chk("post_reset_upper_zero", last_m[511:32], 0);
    chk("post_reset_t", last_t, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
